// File: rtl/fetch_pkg.sv
// fetch_pkg: shared encodings for the instruction-fetch sequencer and the PC unit.
// Holds the FSM state type, opcode class nibbles and instruction field layout.
package fetch_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_HALTED = 3'd3,
        ST_FAULT  = 3'd4
    } fetch_state_e;

    // Opcode class lives in the top nibble of the opcode field
    localparam int unsigned OP_CLASS_W = 4;

    localparam logic [OP_CLASS_W-1:0] HALT_NIBBLE  = 4'hF;
    localparam logic [OP_CLASS_W-1:0] PC_OP_NIBBLE = 4'b0111;

    // Instruction word layout: {opcode, operand}; operand occupies the low half,
    // opcode the high half of a 2*DATA_WIDTH word.
    localparam int unsigned OPERAND_LSB = 0;

    // Width of the fetch timeout counter (covers TIMEOUT_CYCLES up to 65535)
    localparam int unsigned TIMEOUT_CNT_W = 16;

    function automatic logic is_halt(input logic [OP_CLASS_W-1:0] op_class);
        return op_class == HALT_NIBBLE;
    endfunction

    function automatic logic is_pc_op(input logic [OP_CLASS_W-1:0] op_class);
        return op_class == PC_OP_NIBBLE;
    endfunction

endpackage

// File: rtl/fetch_timeout_counter.sv
// fetch_timeout_counter: counts memory-request cycles without an acknowledge.
// expire_o flags the cycle in which the TIMEOUT_CYCLES-th unacknowledged
// request cycle is being counted, so the owner can leave on that edge.
module fetch_timeout_counter
    import fetch_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = TIMEOUT_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic en_i,
    output logic expire_o
);

    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign expire_o = en_i && (count_q == LAST_COUNT);

    // Next count: clear wins, otherwise advance while enabled (held at the limit)
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i && !expire_o) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction-fetch controller driving the PC unit.
// Fetches {opcode, operand} at pc over a req/ack handshake, issues it to the
// datapath over valid/ready and strobes pc_step once per retired instruction.
// Optional retired-instruction counter enabled by defining FETCH_PERF_EN.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    run,
    input  logic                    step,
    input  logic [DATA_WIDTH-1:0]   pc,
    output logic                    imem_req,
    output logic [ADDR_WIDTH-1:0]   imem_addr,
    input  logic                    imem_ack,
    input  logic [2*DATA_WIDTH-1:0] imem_data,
    output logic                    exec_valid,
    input  logic                    exec_ready,
    output logic [DATA_WIDTH-1:0]   opcode,
    output logic [DATA_WIDTH-1:0]   operand,
    output logic                    pc_step,
    output logic                    halted,
    output logic                    fault,
    output logic [31:0]             retired_count
);

    fetch_state_e          state_q;
    logic                  step_q;
    logic                  req_q;
    logic                  valid_q;
    logic [DATA_WIDTH-1:0] opcode_q;
    logic [DATA_WIDTH-1:0] operand_q;
    logic                  halted_q;
    logic                  fault_q;

    logic                  step_rise;
    logic                  start_fetch;
    logic [DATA_WIDTH-1:0] fetch_opcode;
    logic [DATA_WIDTH-1:0] fetch_operand;
    logic                  fetch_is_halt;
    logic                  tmo_clear;
    logic                  tmo_en;
    logic                  tmo_expire;

    // Single-step only counts on a fresh 0->1 edge; run=1 alone starts fetching
    assign step_rise   = step & ~step_q;
    assign start_fetch = run | step_rise;

    assign fetch_opcode  = imem_data[2*DATA_WIDTH-1:DATA_WIDTH];
    assign fetch_operand = imem_data[OPERAND_LSB +: DATA_WIDTH];
    assign fetch_is_halt = is_halt(fetch_opcode[DATA_WIDTH-1 -: OP_CLASS_W]);

    // Counter runs only across consecutive unacknowledged REQ cycles
    assign tmo_en    = (state_q == ST_REQ) && !imem_ack;
    assign tmo_clear = (state_q != ST_REQ) || imem_ack;

    fetch_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (TIMEOUT_CNT_W)
    ) u_timeout (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (tmo_clear),
        .en_i     (tmo_en),
        .expire_o (tmo_expire)
    );

    // The address tracks pc combinationally while requesting, so a REQ that
    // follows a pc_step sees the PC unit's freshly updated value.
    assign imem_addr  = req_q ? pc[ADDR_WIDTH-1:0] : '0;
    assign imem_req   = req_q;
    assign exec_valid = valid_q;
    assign opcode     = opcode_q;
    assign operand    = operand_q;
    assign halted     = halted_q;
    assign fault      = fault_q;

    // Strobe is the live handshake so the PC unit advances on that edge only
    assign pc_step = valid_q & exec_ready;

    // Fetch FSM with registered request/valid/status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            step_q    <= 1'b0;
            req_q     <= 1'b0;
            valid_q   <= 1'b0;
            opcode_q  <= '0;
            operand_q <= '0;
            halted_q  <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            step_q <= step;
            case (state_q)
                ST_IDLE: begin
                    if (start_fetch) begin
                        state_q <= ST_REQ;
                        req_q   <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (imem_ack) begin
                        opcode_q  <= fetch_opcode;
                        operand_q <= fetch_operand;
                        req_q     <= 1'b0;
                        if (fetch_is_halt) begin
                            state_q  <= ST_HALTED;
                            halted_q <= 1'b1;
                        end else begin
                            state_q <= ST_ISSUE;
                            valid_q <= 1'b1;
                        end
                    end else if (tmo_expire) begin
                        state_q <= ST_FAULT;
                        req_q   <= 1'b0;
                        fault_q <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (exec_ready) begin
                        valid_q <= 1'b0;
                        if (run) begin
                            state_q <= ST_REQ;
                            req_q   <= 1'b1;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_HALTED, ST_FAULT: begin
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] retired_q;
    logic [31:0] retired_d;

    // Saturating count of retired instructions
    always_comb begin
        retired_d = retired_q;
        if (pc_step && (retired_q != '1)) begin
            retired_d = retired_q + 32'd1;
        end
    end

    // Retired counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            retired_q <= '0;
        end else begin
            retired_q <= retired_d;
        end
    end

    assign retired_count = retired_q;
`else
    assign retired_count = '0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed tests for fetch_sequencer with a behavioural
// program memory (programmable ack latency) and a PC unit that increments on pc_step.
module tb_fetch_sequencer;

    localparam int unsigned DW  = 16;
    localparam int unsigned AW  = 16;
    localparam int unsigned TMO = 4;

`ifdef FETCH_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset, run, step;
    logic [DW-1:0] pc;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [2*DW-1:0] imem_data;
    logic          exec_valid, exec_ready;
    logic [DW-1:0] opcode, operand;
    logic          pc_step, halted, fault;
    logic [31:0]   retired_count;

    int n_checks = 0;
    int n_fail   = 0;

    int unsigned mem_lat;       // ack on this REQ cycle; 0 = never ack
    logic [31:0] mem_word;
    logic        ready_level;
    int unsigned req_age;
    logic        step_pending;
    int unsigned n_steps;

    always #5 clk = ~clk;

    fetch_sequencer #(
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .run           (run),
        .step          (step),
        .pc            (pc),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_data     (imem_data),
        .exec_valid    (exec_valid),
        .exec_ready    (exec_ready),
        .opcode        (opcode),
        .operand       (operand),
        .pc_step       (pc_step),
        .halted        (halted),
        .fault         (fault),
        .retired_count (retired_count)
    );

    // One clock: PC unit update, memory and datapath responses, then sample pc_step
    task automatic clk_cycle();
        @(posedge clk);
        #1;
        if (step_pending) pc = pc + 1'b1;
        if (imem_req) begin
            req_age++;
            imem_ack = (mem_lat != 0) && (req_age >= mem_lat);
        end else begin
            req_age  = 0;
            imem_ack = 1'b0;
        end
        imem_data  = imem_ack ? mem_word : 32'hDEAD_BEEF;
        exec_ready = ready_level;
        #1;
        step_pending = pc_step;
        if (pc_step) n_steps++;
    endtask

    task automatic reset_dut();
        reset = 1'b1; run = 1'b0; step = 1'b0;
        imem_ack = 1'b0; imem_data = '0; exec_ready = 1'b0;
        pc = '0; ready_level = 1'b0; mem_lat = 1; mem_word = '0;
        req_age = 0; step_pending = 1'b0; n_steps = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset_dut();
        n_checks++;
        if ({imem_req, exec_valid, pc_step, halted, fault} !== 5'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b expected 00000", {imem_req, exec_valid, pc_step, halted, fault});
        end
        n_checks++;
        if ({opcode, operand} !== 32'h0) begin
            n_fail++; $display("FAIL reset_instr: got %h expected 00000000", {opcode, operand});
        end
        n_checks++;
        if (imem_addr !== 16'h0) begin
            n_fail++; $display("FAIL reset_addr: got %h expected 0000", imem_addr);
        end
        n_checks++;
        if (retired_count !== 32'h0) begin
            n_fail++; $display("FAIL reset_retired: got %0d expected 0", retired_count);
        end
    endtask

    task automatic test_run();
        reset_dut();
        mem_lat = 1; mem_word = 32'h1000_0042; ready_level = 1'b1; run = 1'b1;
        for (int unsigned c = 1; c <= 10; c++) begin
            clk_cycle();
            n_checks++;
            if (pc_step !== ((c % 2) == 0)) begin
                n_fail++; $display("FAIL run_step_c%0d: got %b expected %b", c, pc_step, (c % 2) == 0);
            end
            if (pc_step) begin
                n_checks++;
                if ({opcode, operand} !== 32'h1000_0042) begin
                    n_fail++; $display("FAIL run_instr_c%0d: got %h expected 10000042", c, {opcode, operand});
                end
            end
            if (imem_req) begin
                n_checks++;
                if (imem_addr !== pc) begin
                    n_fail++; $display("FAIL run_addr_c%0d: got %h expected %h", c, imem_addr, pc);
                end
            end
        end
        run = 1'b0;
        repeat (3) clk_cycle();
        n_checks++;
        if (n_steps !== 5 || pc !== 16'd5) begin
            n_fail++; $display("FAIL run_count: got steps=%0d pc=%0d expected steps=5 pc=5", n_steps, pc);
        end
        n_checks++;
        if ({imem_req, exec_valid} !== 2'b00) begin
            n_fail++; $display("FAIL run_stop_idle: got %b expected 00", {imem_req, exec_valid});
        end
        n_checks++;
        if (retired_count !== (PERF ? 32'd5 : 32'd0)) begin
            n_fail++; $display("FAIL run_retired: got %0d expected %0d", retired_count, PERF ? 5 : 0);
        end
    endtask

    task automatic test_single_step();
        reset_dut();
        mem_lat = 3; mem_word = 32'h2000_0011; ready_level = 1'b1;
        step = 1'b1; clk_cycle(); step = 1'b0;
        repeat (7) clk_cycle();
        n_checks++;
        if (n_steps !== 1 || pc !== 16'd1) begin
            n_fail++; $display("FAIL step1_count: got steps=%0d pc=%0d expected steps=1 pc=1", n_steps, pc);
        end
        n_checks++;
        if ({imem_req, exec_valid} !== 2'b00) begin
            n_fail++; $display("FAIL step1_idle: got %b expected 00", {imem_req, exec_valid});
        end
        n_checks++;
        if ({opcode, operand} !== 32'h2000_0011) begin
            n_fail++; $display("FAIL step1_instr: got %h expected 20000011", {opcode, operand});
        end
        step = 1'b1; clk_cycle(); step = 1'b0;
        repeat (7) clk_cycle();
        n_checks++;
        if (n_steps !== 2 || pc !== 16'd2) begin
            n_fail++; $display("FAIL step2_count: got steps=%0d pc=%0d expected steps=2 pc=2", n_steps, pc);
        end
        // A second edge arriving while the fetch is in flight is dropped
        step = 1'b1; clk_cycle(); step = 1'b0; clk_cycle();
        step = 1'b1; clk_cycle(); step = 1'b0;
        repeat (7) clk_cycle();
        n_checks++;
        if (n_steps !== 3 || pc !== 16'd3) begin
            n_fail++; $display("FAIL step_busy_ignored: got steps=%0d pc=%0d expected steps=3 pc=3", n_steps, pc);
        end
    endtask

    task automatic test_ready_stall();
        reset_dut();
        mem_lat = 1; mem_word = 32'h3000_0077; ready_level = 1'b0;
        step = 1'b1; clk_cycle(); step = 1'b0;
        for (int unsigned c = 2; c <= 6; c++) begin
            clk_cycle();
            n_checks++;
            if ({exec_valid, pc_step} !== 2'b10 || {opcode, operand} !== 32'h3000_0077) begin
                n_fail++; $display("FAIL stall_c%0d: got valid=%b step=%b instr=%h expected valid=1 step=0 instr=30000077",
                                   c, exec_valid, pc_step, {opcode, operand});
            end
        end
        ready_level = 1'b1;
        clk_cycle();
        n_checks++;
        if ({exec_valid, pc_step} !== 2'b11) begin
            n_fail++; $display("FAIL stall_release: got valid=%b step=%b expected 1 1", exec_valid, pc_step);
        end
        clk_cycle();
        n_checks++;
        if ({exec_valid, pc_step, imem_req} !== 3'b000 || n_steps !== 1) begin
            n_fail++; $display("FAIL stall_after: got valid=%b step=%b req=%b steps=%0d expected 0 0 0 1",
                               exec_valid, pc_step, imem_req, n_steps);
        end
    endtask

    task automatic test_pc_op();
        reset_dut();
        mem_lat = 1; mem_word = 32'h7ABC_0005; ready_level = 1'b1;
        step = 1'b1; clk_cycle(); step = 1'b0;
        repeat (4) clk_cycle();
        n_checks++;
        if (n_steps !== 1 || pc !== 16'd1 || {opcode, operand} !== 32'h7ABC_0005 || halted !== 1'b0) begin
            n_fail++; $display("FAIL pc_op: got steps=%0d pc=%0d instr=%h halted=%b expected 1 1 7abc0005 0",
                               n_steps, pc, {opcode, operand}, halted);
        end
    endtask

    task automatic test_halt();
        reset_dut();
        mem_lat = 1; mem_word = 32'hF000_1234; ready_level = 1'b1; run = 1'b1;
        clk_cycle();
        for (int unsigned c = 2; c <= 8; c++) begin
            clk_cycle();
            n_checks++;
            if ({halted, imem_req, exec_valid, pc_step} !== 4'b1000) begin
                n_fail++; $display("FAIL halt_c%0d: got halted/req/valid/step=%b expected 1000",
                                   c, {halted, imem_req, exec_valid, pc_step});
            end
        end
        run = 1'b0;
        step = 1'b1; clk_cycle(); step = 1'b0;
        repeat (3) clk_cycle();
        n_checks++;
        if ({halted, imem_req, fault} !== 3'b100 || n_steps !== 0) begin
            n_fail++; $display("FAIL halt_sticky: got halted/req/fault=%b steps=%0d expected 100 0",
                               {halted, imem_req, fault}, n_steps);
        end
    endtask

    task automatic test_timeout();
        reset_dut();
        mem_lat = 0; ready_level = 1'b1; run = 1'b1;
        for (int unsigned c = 1; c <= 4; c++) begin
            clk_cycle();
            n_checks++;
            if ({imem_req, fault} !== 2'b10) begin
                n_fail++; $display("FAIL tmo_req_c%0d: got req/fault=%b expected 10", c, {imem_req, fault});
            end
        end
        for (int unsigned c = 5; c <= 7; c++) begin
            clk_cycle();
            n_checks++;
            if ({imem_req, fault, exec_valid} !== 3'b010) begin
                n_fail++; $display("FAIL tmo_fault_c%0d: got req/fault/valid=%b expected 010",
                                   c, {imem_req, fault, exec_valid});
            end
        end
    endtask

    task automatic test_timeout_boundary();
        reset_dut();
        mem_lat = TMO; mem_word = 32'h4000_0009; ready_level = 1'b1;
        step = 1'b1; clk_cycle(); step = 1'b0;
        repeat (7) clk_cycle();
        n_checks++;
        if (fault !== 1'b0 || n_steps !== 1) begin
            n_fail++; $display("FAIL tmo_boundary: got fault=%b steps=%0d expected 0 1", fault, n_steps);
        end
    endtask

    task automatic test_reset_abort();
        reset_dut();
        mem_lat = 1; mem_word = 32'h1000_0042; ready_level = 1'b1; run = 1'b1;
        clk_cycle(); clk_cycle();
        mem_lat = 0;
        clk_cycle();
        n_checks++;
        if (imem_req !== 1'b1 || n_steps !== 1) begin
            n_fail++; $display("FAIL abort_setup: got req=%b steps=%0d expected 1 1", imem_req, n_steps);
        end
        reset = 1'b1; run = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (imem_req !== 1'b0) begin
            n_fail++; $display("FAIL abort_req_drop: got %b expected 0", imem_req);
        end
        imem_ack = 1'b1; imem_data = 32'h5000_0055; reset = 1'b0;
        @(posedge clk); #1;
        imem_ack = 1'b0; imem_data = '0;
        #1;
        n_checks++;
        if ({imem_req, exec_valid, pc_step, halted, fault, opcode, operand, imem_addr} !== 53'h0) begin
            n_fail++; $display("FAIL abort_outputs: got req=%b valid=%b step=%b halted=%b fault=%b instr=%h addr=%h expected all 0",
                               imem_req, exec_valid, pc_step, halted, fault, {opcode, operand}, imem_addr);
        end
        n_checks++;
        if (retired_count !== 32'h0) begin
            n_fail++; $display("FAIL abort_retired: got %0d expected 0", retired_count);
        end
        step_pending = 1'b0;
        repeat (3) clk_cycle();
        n_checks++;
        if ({imem_req, exec_valid} !== 2'b00) begin
            n_fail++; $display("FAIL abort_stays_idle: got %b expected 00", {imem_req, exec_valid});
        end
    endtask

    initial begin
        test_reset();
        test_run();
        test_single_step();
        test_ready_stall();
        test_pc_op();
        test_halt();
        test_timeout();
        test_timeout_boundary();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
